// File: rtl/load_ctrl_pkg.sv
// Shared types and constants for the program-load sequencer.
// Build option: LOAD_CKSUM_EN adds the checksum trailer state.
package load_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLen   = 3'd1,
    StData  = 3'd2,
`ifdef LOAD_CKSUM_EN
    StCksum = 3'd3,
`endif
    StRun   = 3'd4,
    StErr   = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CKSUM   = 2'd3;

  localparam int unsigned BYTE_IDX_W = 2;

  // States that are inside a frame: the timeout runs and busy is reported.
  function automatic logic in_frame_state(state_e s);
`ifdef LOAD_CKSUM_EN
    return (s == StLen) || (s == StData) || (s == StCksum);
`else
    return (s == StLen) || (s == StData);
`endif
  endfunction

endpackage

// File: rtl/load_ctrl_word_asm.sv
// Little-endian word assembler: collects four bytes into a 32-bit word.
// word_valid is asserted combinationally alongside the byte that completes a word.
module word_asm
  import load_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [BYTE_IDX_W-1:0] cnt_q;
  logic [23:0]           lanes_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q   <= '0;
      lanes_q <= '0;
    end else if (byte_valid) begin
      cnt_q <= cnt_q + BYTE_IDX_W'(1);
      unique case (cnt_q)
        2'd0:    lanes_q[7:0]   <= byte_in;
        2'd1:    lanes_q[15:8]  <= byte_in;
        2'd2:    lanes_q[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  assign word_valid = byte_valid && (cnt_q == '1);
  assign word       = {byte_in, lanes_q};

endmodule

// File: rtl/load_ctrl.sv
// Program-load and run sequencer: length-prefixed UART image into instruction memory.
// Build option: LOAD_CKSUM_EN requires and checks an XOR checksum trailer byte.
module load_ctrl
  import load_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset,
  output logic              core_run,
  output logic              busy,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q, state_d;
  logic [1:0]        err_q, err_d;
  logic [7:0]        len_lsb_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   words_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              mem_we_q, core_reset_q, core_run_q, busy_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;

  logic        in_frame, tmo_hit, restart, len_ok, byte_valid, word_valid, last_word;
  logic [15:0] len_rx;
  logic [31:0] word;
`ifdef LOAD_CKSUM_EN
  logic [7:0]  xor_q;
`endif

  // Any byte outside a frame starts a new load and is the length LSB.
  assign restart    = rx_dv && (state_q inside {StIdle, StRun, StErr});
  assign in_frame   = in_frame_state(state_q);
  assign tmo_hit    = in_frame && !rx_dv && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign len_rx     = {rx_byte, len_lsb_q};
  assign len_ok     = (len_rx != 16'd0) && (32'(len_rx) <= DEPTH);
  assign byte_valid = rx_dv && (state_q == StData);
  assign last_word  = word_valid && ((words_q + (ADDR_W + 1)'(1)) == len_q);

  word_asm u_word_asm (
    .clk        (clk),
    .clr        (reset || restart),
    .byte_valid (byte_valid),
    .byte_in    (rx_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle, StRun, StErr: begin
        if (rx_dv) begin
          state_d = StLen;
          err_d   = ERR_NONE;
        end
      end
      StLen: begin
        if (rx_dv) begin
          if (len_ok) begin
            state_d = StData;
          end else begin
            state_d = StErr;
            err_d   = ERR_LEN;
          end
        end
      end
      StData: begin
        if (last_word) begin
`ifdef LOAD_CKSUM_EN
          state_d = StCksum;
`else
          state_d = StRun;
`endif
        end
      end
`ifdef LOAD_CKSUM_EN
      StCksum: begin
        if (rx_dv) begin
          if (rx_byte == xor_q) begin
            state_d = StRun;
          end else begin
            state_d = StErr;
            err_d   = ERR_CKSUM;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
    // tmo_hit implies no byte this cycle, so an arriving byte always wins.
    if (tmo_hit) begin
      state_d = StErr;
      err_d   = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      err_q        <= ERR_NONE;
      len_lsb_q    <= '0;
      len_q        <= '0;
      words_q      <= '0;
      tmo_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_reset_q <= 1'b1;
      core_run_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      core_reset_q <= (state_d != StRun);
      core_run_q   <= (state_d == StRun);
      busy_q       <= in_frame_state(state_d);
      tmo_q        <= (in_frame && !rx_dv) ? tmo_q + TMO_W'(1) : '0;
      mem_we_q     <= 1'b0;
      if (restart) begin
        len_lsb_q <= rx_byte;
        words_q   <= '0;
      end
      if (rx_dv && (state_q == StLen)) begin
        len_q <= (ADDR_W + 1)'(len_rx);
      end
      if (word_valid) begin
        mem_we_q    <= 1'b1;
        mem_addr_q  <= words_q[ADDR_W-1:0];
        mem_wdata_q <= word;
        words_q     <= words_q + (ADDR_W + 1)'(1);
      end
    end
  end

`ifdef LOAD_CKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      xor_q <= '0;
    end else if (byte_valid) begin
      xor_q <= xor_q ^ rx_byte;
    end
  end
`endif

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign core_reset   = core_reset_q;
  assign core_run     = core_run_q;
  assign busy         = busy_q;
  assign err_code     = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_load_ctrl.sv
// Self-checking bench for load_ctrl: frame table plus hand-written corner sequences.
// Honours LOAD_CKSUM_EN by appending the XOR trailer to every payload-carrying frame.
module tb_load_ctrl;

  localparam int unsigned ADDR_W         = 8;
  localparam int unsigned TIMEOUT_CYCLES = 50;
  localparam int unsigned DEPTH          = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_dv;
  logic [7:0]        rx_byte;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_reset;
  logic              core_run;
  logic              busy;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  load_ctrl #(
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_dv        (rx_dv),
    .rx_byte      (rx_byte),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_reset   (core_reset),
    .core_run     (core_run),
    .busy         (busy),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    logic [15:0] len;
    int          nw;
    logic [31:0] w0, w1, w2;
    logic        exp_run;
    logic [1:0]  exp_err;
    int          exp_wl;
  } vec_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  wr_t         push_e;
  vec_t        vt[5];
  logic [31:0] fw[DEPTH];
  int          errors = 0;
  int          checks = 0;
  int          waited;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write on port A must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", mem_addr,
                 mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
        check("wr_data", mem_wdata, mon_e.data);
        check("wl_at_write", 32'(words_loaded), 32'(mon_e.addr) + 1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    rx_dv   = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] len, input int nw, input bit bad_ck);
    logic [7:0] x;
    logic [7:0] b;
    bit         ok;
    x  = 8'h00;
    ok = (len != 16'd0) && (32'(len) <= DEPTH);
    send_byte(len[7:0]);
    check("first_byte_core_reset", 32'(core_reset), 1);
    check("first_byte_busy", 32'(busy), 1);
    send_byte(len[15:8]);
    for (int i = 0; i < nw; i++) begin
      if (ok) begin
        push_e.addr = ADDR_W'(i);
        push_e.data = fw[i];
        exp_q.push_back(push_e);
      end
      for (int k = 0; k < 4; k++) begin
        b = fw[i][8*k +: 8];
        x = x ^ b;
        send_byte(b);
      end
    end
`ifdef LOAD_CKSUM_EN
    if (nw > 0) send_byte(bad_ck ? (x ^ 8'h01) : x);
`else
    if (bad_ck) $display("note: checksum corruption ignored in this build");
`endif
  endtask

  task automatic check_end(input string tag, input logic run, input logic [1:0] err,
                           input int wl);
    check({tag, "_core_run"}, 32'(core_run), 32'(run));
    check({tag, "_core_reset"}, 32'(core_reset), 32'(!run));
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err_code"}, 32'(err_code), 32'(err));
    check({tag, "_words_loaded"}, 32'(words_loaded), wl);
  endtask

  initial begin
    vt[0] = '{16'h0001, 1, 32'h0000_0013, 32'h0, 32'h0, 1'b1, 2'd0, 1};
    vt[1] = '{16'h0003, 3, 32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 1'b1, 2'd0, 3};
    vt[2] = '{16'h0000, 0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd1, 0};
    vt[3] = '{16'h0101, 0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd1, 0};
    vt[4] = '{16'h0002, 2, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0, 1'b1, 2'd0, 2};

    reset   = 1'b1;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check_end("rst", 1'b0, 2'd0, 0);

    // Table: each frame after the first restarts from RUN or ERR.
    for (int v = 0; v < 5; v++) begin
      fw[0] = vt[v].w0;
      fw[1] = vt[v].w1;
      fw[2] = vt[v].w2;
      send_frame(vt[v].len, vt[v].nw, 1'b0);
      check_end($sformatf("vec%0d", v), vt[v].exp_run, vt[v].exp_err, vt[v].exp_wl);
      repeat (3) @(posedge clk);
      #1;
    end

    // Largest legal image fills every address.
    for (int i = 0; i < int'(DEPTH); i++) fw[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'hA5};
    send_frame(16'h0100, int'(DEPTH), 1'b0);
    check_end("full", 1'b1, 2'd0, int'(DEPTH));
    repeat (3) @(posedge clk);
    #1;

    // Stall mid-word until the inter-byte timeout fires.
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h77);
    send_byte(8'h66);
    waited = 0;
    while (err_code != 2'd2 && waited < 4 * TIMEOUT_CYCLES) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_end("timeout", 1'b0, 2'd2, 0);
    checks++;
    if (waited < TIMEOUT_CYCLES - 1 || waited > TIMEOUT_CYCLES + 1) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles, expected about %0d", waited,
               TIMEOUT_CYCLES);
    end

`ifdef LOAD_CKSUM_EN
    fw[0] = 32'h0102_0304;
    send_frame(16'h0001, 1, 1'b0);
    check_end("cksum_good", 1'b1, 2'd0, 1);
    repeat (2) @(posedge clk);
    #1;
    send_frame(16'h0001, 1, 1'b1);
    check_end("cksum_bad", 1'b0, 2'd3, 1);
    repeat (2) @(posedge clk);
    #1;
`endif

    // Reset in the middle of a word: back to IDLE, nothing written.
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_mem_we", 32'(mem_we), 0);
    check_end("midrst", 1'b0, 2'd0, 0);
    repeat (5) @(posedge clk);
    #1;
    fw[0] = 32'hCAFE_F00D;
    send_frame(16'h0001, 1, 1'b0);
    check_end("after_rst", 1'b1, 2'd0, 1);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_ctrl.md
# load_ctrl

Program-load and run sequencer between the UART receiver and the core. Parses a length-prefixed byte stream from `uart_rx`, assembles little-endian 32-bit words, and writes them through instruction-memory port A. It holds the program counter and core in reset while loading, then releases them once a complete, valid image is in memory. Any new byte arriving while running or in error restarts the load.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width; depth `DEPTH = 2**ADDR_W`.
- `TIMEOUT_CYCLES`, 1000000: maximum idle clocks between bytes inside a frame.
- `clk`  in  1  system clock.
- `reset`  in  1  system reset; one clock; reset is synchronous and active-high.
- `rx_dv`  in  1  one-cycle strobe, `rx_byte` valid.
- `rx_byte`  in  8  received byte.
- `mem_we`  out  1  port-A write enable, one-cycle pulse per word.
- `mem_addr`  out  ADDR_W  port-A word address.
- `mem_wdata`  out  32  port-A write data.
- `core_reset`  out  1  drives the `pc`/core reset; high except in RUN.
- `core_run`  out  1  high only in RUN.
- `busy`  out  1  high in LEN, DATA, CKSUM.
- `err_code`  out  2  0 none, 1 bad length, 2 timeout, 3 checksum; valid in ERR.
- `words_loaded`  out  ADDR_W+1  words written in the current or last load.

## Operation
- Frame format: 2-byte length N (LSB first), then 4·N payload bytes (each word LSB first), then 1 checksum byte (only with the macro).
- Valid N is 1..DEPTH. N=0 or N>DEPTH sets `err_code`=1 and goes to ERR on the second length byte.
- FSM states: IDLE, LEN, DATA, CKSUM, RUN, ERR.
- IDLE: first `rx_dv` latches length LSB and goes to LEN.
- LEN: `rx_dv` latches MSB and validates N. Valid N goes to DATA; invalid N goes to ERR.
- DATA: bytes go to `word_asm`. On the 4th byte of each word, issue a write and increment the word index. After word N-1 is written, go to CKSUM if the macro is defined, otherwise to RUN.
- CKSUM: compare the received byte with the running XOR of all payload bytes. Equal goes to RUN; unequal sets `err_code`=3 and goes to ERR.
- RUN, ERR: any `rx_dv` restarts the load. That byte is taken as the length LSB, the state goes to LEN, `core_reset` rises, `err_code` and `words_loaded` clear, and the word index and XOR reset.
- Timeout: a counter runs only in LEN, DATA, CKSUM and clears on every `rx_dv`. Reaching TIMEOUT_CYCLES-1 with no byte sets `err_code`=2 and goes to ERR.
- If a byte and the timeout occur in the same cycle, the byte wins.
- Word index wraps never: N ≤ DEPTH, so the last address is N-1 ≤ DEPTH-1. `words_loaded` is ADDR_W+1 bits so it can hold DEPTH.
- Memory contents beyond N-1 are untouched.

## Timing
- Reset values: state IDLE, `core_reset`=1, `core_run`=0, `busy`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `err_code`=0, `words_loaded`=0.
- All outputs are registered.
- `mem_we` pulses in the cycle after the `rx_dv` that carries byte 3 of a word. `mem_addr` and `mem_wdata` are stable in that cycle.
- `words_loaded` increments in the same cycle as `mem_we`.
- `core_reset` falls and `core_run` rises in the cycle after the final accepted byte (the last payload byte, or the checksum byte). The PC starts at 0 on the next edge.
- `core_reset` rises in the cycle after a restart byte.
- `reset` asserted mid-load aborts to IDLE next cycle; no partial word is written.
- Back-to-back `rx_dv` on consecutive cycles must be accepted.

## Configuration
- `LOAD_CKSUM_EN` defined: CKSUM state is present, a trailer byte is required, and `err_code`=3 is reachable.
- `LOAD_CKSUM_EN` undefined: no CKSUM state and no XOR register; DATA goes directly to RUN; `err_code` is never 3.

## Structure
- Package `load_ctrl_pkg`:
  - state encoding (3-bit enum);
  - `err_code` constants `ERR_NONE`, `ERR_LEN`, `ERR_TIMEOUT`, `ERR_CKSUM`;
  - byte-index width constant.
- Sub-module `word_asm`: 2-bit byte counter plus 32-bit little-endian shift/lane register.
  - Outputs `word_valid` and `word`.
  - Synchronous clear input used on restart and reset.

## Test plan
- Frame `01 00 13 00 00 00` (N=1, word 0x00000013, no cksum) -> one `mem_we` at addr 0, data 0x00000013; `core_run`=1 one cycle after the 6th byte.
- N=3 words 0x11223344, 0x55667788, 0x99AABBCC -> writes at addrs 0,1,2; `words_loaded`=3; RUN.
- Length `00 00` -> ERR, `err_code`=1, no `mem_we`; length `01 01` (257) with ADDR_W=8 -> ERR, `err_code`=1.
- Stop after 2 payload bytes for TIMEOUT_CYCLES (bench TIMEOUT_CYCLES=50) -> ERR, `err_code`=2, `core_reset`=1, no write.
- With `LOAD_CKSUM_EN`, N=1 word 0x01020304: trailer 0x04 -> RUN; trailer 0x05 -> ERR, `err_code`=3.
- In RUN, send a new N=1 frame -> `core_reset`=1 the cycle after its first byte; reload writes addr 0; RUN again. Assert `reset` mid-DATA -> IDLE, no write.
